logs_vol_mixer: RTL and testbench



---
 rtl/logs_vol_mixer_pkg.sv | 5 +
 rtl/logs_vol_mixer_wsum.sv | 17 +
 rtl/logs_vol_mixer.sv | 84 ++++++++
 tb/tb_logs_vol_mixer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/logs_vol_mixer_pkg.sv
// logs_vol_mixer_pkg: shared modulator mode encodings for the volume mixer.
package logs_vol_mixer_pkg;
    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_DSM = 1'b1;
endpackage

// File: rtl/logs_vol_mixer_wsum.sv
// logs_vol_mixer_wsum: combinational masked weighted sum of 1-bit voices.
module logs_wsum #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int SUM_W = W + $clog2(N + 1)
) (
    input  logic [N-1:0]     audio_in,
    input  logic [N-1:0]     audio_mask,
    input  logic [N*W-1:0]   volume,
    output logic [SUM_W-1:0] sum_o
);
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < N; i++)
            sum_o = sum_o + ((audio_in[i] & audio_mask[i]) ? SUM_W'(volume[i*W +: W]) : '0);
    end
endmodule

// File: rtl/logs_vol_mixer.sv
// logs_vol_mixer: per-channel volume mixer driving a 1-bit PWM or delta-sigma output.
module logs_vol_mixer
    import logs_vol_mixer_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4,
    parameter int K = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   audio_in,
    input  logic [N-1:0]   audio_mask,
    input  logic [N*W-1:0] volume,
    input  logic           mode,
    output logic           audio_out,
    output logic           frame_tick
);
    localparam int SUM_W = W + $clog2(N + 1);
    localparam int XW = (SUM_W > K) ? SUM_W : K + 1;
    localparam logic [K-1:0] MAXV = '1;

    logic [SUM_W-1:0] wsum, sum_q;
    logic [XW-1:0]    sum_x;
    logic [K-1:0]     sat, counter_q, counter_d, duty_q, duty_d, acc_q, acc_d;
    logic [K:0]       dsum;
    logic             mode_q, out_q, out_d, tick_q, tick_d;

    logs_wsum #(.N(N), .W(W)) u_wsum (
        .audio_in   (audio_in),
        .audio_mask (audio_mask),
        .volume     (volume),
        .sum_o      (wsum)
    );

    // Clamp to full scale so loud mixes pin at max duty instead of wrapping.
    assign sum_x = XW'(sum_q);
    assign sat   = (sum_x > XW'(MAXV)) ? MAXV : sum_x[K-1:0];
    assign dsum  = {1'b0, acc_q} + {1'b0, sat};

    always_comb begin
        counter_d = counter_q;
        duty_d    = duty_q;
        acc_d     = acc_q;
        out_d     = 1'b0;
        tick_d    = 1'b0;
        if (mode != mode_q) begin
            counter_d = '0;
            duty_d    = '0;
            acc_d     = '0;
        end else if (mode_q == MODE_PWM) begin
            counter_d = counter_q + 1'b1;
            duty_d    = (counter_q == MAXV) ? sat : duty_q;
            out_d     = counter_q < duty_q;
            tick_d    = counter_q == '0;
        end else begin
            counter_d = '0;
            acc_d     = dsum[K-1:0];
            out_d     = dsum[K];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            mode_q    <= MODE_PWM;
            counter_q <= '0;
            duty_q    <= '0;
            acc_q     <= '0;
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            sum_q     <= wsum;
            mode_q    <= mode;
            counter_q <= counter_d;
            duty_q    <= duty_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
        end
    end

    assign audio_out  = out_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_logs_vol_mixer.sv
// tb_logs_vol_mixer: directed checks of PWM, DSM, saturation, masking and mode switching.
module tb_logs_vol_mixer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  audio_in, audio_mask, in5, mask5;
    logic [15:0] volume, vol5;
    logic        mode, mode5;
    logic        audio_out, frame_tick, out5, tick5;
    int          n_tests = 0, n_fail = 0;

    logs_vol_mixer #(.N(4), .W(4), .K(6)) dut (
        .clk(clk), .reset(reset), .audio_in(audio_in), .audio_mask(audio_mask),
        .volume(volume), .mode(mode), .audio_out(audio_out), .frame_tick(frame_tick)
    );

    logs_vol_mixer #(.N(4), .W(4), .K(5)) dut5 (
        .clk(clk), .reset(reset), .audio_in(in5), .audio_mask(mask5),
        .volume(vol5), .mode(mode5), .audio_out(out5), .frame_tick(tick5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int duty[4] = '{0, 12, 12, 20};
        int ones[4] = '{0, 0, 0, 0};
        int perr = 0, terr = 0, ticks = 0, o, t, k, found;
        audio_in = 4'b0011; audio_mask = 4'hF; volume = 16'h0075; mode = 1'b0;
        in5 = 4'hF; mask5 = 4'hF; vol5 = 16'hFFFF; mode5 = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(100);
        reset = 1'b1;
        cyc(3);
        check("rst_out", audio_out, 0);
        check("rst_tick", frame_tick, 0);
        reset = 1'b0;
        for (int s = 0; s < 212; s++) begin
            cyc(1);
            if (s == 0) check("tick_first", frame_tick, 1);
            ones[s / 64] += audio_out;
            ticks += frame_tick;
            if (audio_out != ((s % 64) < duty[s / 64])) perr++;
            if (frame_tick != (s % 64 == 0)) terr++;
            if (s == 130) volume = 16'h00F5;
        end
        check("pwm_f1_ones", ones[0], 0);
        check("pwm_f2_ones", ones[1], 12);
        check("pwm_f3_ones", ones[2], 12);
        check("pwm_f4_ones", ones[3], 20);
        check("pwm_pattern_err", perr, 0);
        check("pwm_ticks", ticks, 4);
        check("pwm_tick_pos_err", terr, 0);
        mode = 1'b1; volume = 16'h0075;
        cyc(1);
        check("sw_dsm_out", audio_out, 0);
        check("sw_dsm_tick", frame_tick, 0);
        o = 0; t = 0;
        for (int j = 0; j < 64; j++) begin
            cyc(1);
            o += audio_out;
            t += frame_tick;
        end
        check("dsm_ones", o, 12);
        check("dsm_ticks", t, 0);
        mode = 1'b0;
        cyc(1);
        check("sw_pwm_out", audio_out, 0);
        check("sw_pwm_tick0", frame_tick, 0);
        cyc(1);
        check("sw_pwm_tick1", frame_tick, 1);
        mode = 1'b1;
        cyc(5);
        audio_in = 4'b0000;
        cyc(3);
        check("dsm_pre", audio_out, 0);
        audio_in = 4'b0001;
        cyc(1);
        check("dsm_lat1", audio_out, 0);
        cyc(1);
        check("dsm_lat2", audio_out, 1);
        audio_mask = 4'h0; audio_in = 4'hF; volume = 16'hFFFF;
        cyc(3);
        o = 0;
        for (int j = 0; j < 64; j++) begin
            cyc(1);
            o += audio_out;
        end
        check("mask_dsm_ones", o, 0);
        mode = 1'b0;
        o = 0;
        for (int j = 0; j < 130; j++) begin
            cyc(1);
            o += audio_out;
        end
        check("mask_pwm_ones", o, 0);
        k = 0; found = 0;
        while (k < 64 && found == 0) begin
            cyc(1);
            found = tick5;
            k++;
        end
        check("sat_tick_found", found, 1);
        o = out5;
        for (int j = 1; j < 32; j++) begin
            cyc(1);
            o += out5;
        end
        check("sat_pwm_ones", o, 31);
        mode5 = 1'b1;
        cyc(1);
        check("sat_sw_out", out5, 0);
        o = 0;
        for (int j = 0; j < 32; j++) begin
            cyc(1);
            o += out5;
        end
        check("sat_dsm_ones", o, 31);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
